// File: rtl/module_mult_sequencer.sv
// Sequences a shared shift-add multiplier and then a double-dabble binary-to-BCD
// converter, and presents the registered product and BCD result to the display path.
module module_mult_sequencer #(
    parameter int WIDTH      = 4,
    parameter int BCD_DIGITS = 3
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    start_i,
    input  logic                    abort_i,
    input  logic [WIDTH-1:0]        op_a_i,
    input  logic [WIDTH-1:0]        op_b_i,
    output logic                    busy_o,
    output logic                    done_o,
    output logic                    result_valid_o,
    output logic [2*WIDTH-1:0]      product_o,
    output logic [4*BCD_DIGITS-1:0] result_bcd_o,
    output logic [1:0]              state_dbg_o
);

    localparam int PW = 2 * WIDTH;
    localparam int BW = 4 * BCD_DIGITS;
    localparam int CW = $clog2(2 * WIDTH);
    localparam logic [CW-1:0] LAST_MULT = CW'(WIDTH - 1);
    localparam logic [CW-1:0] LAST_CONV = CW'(2 * WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MULT = 2'd1,
        CONV = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic            startPrev_q;
    logic [WIDTH-1:0] opA_q, opA_d;
    logic [WIDTH-1:0] opB_q, opB_d;
    logic [PW-1:0]   acc_q, acc_d;
    logic [PW-1:0]   binSh_q, binSh_d;
    logic [BW-1:0]   bcd_q, bcd_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [PW-1:0]   product_q, product_d;
    logic [BW-1:0]   resultBcd_q, resultBcd_d;
    logic            resultValid_q, resultValid_d;

    logic            startEdge;
    logic            mulBit;
    logic [PW-1:0]   partial;
    logic [PW-1:0]   accSum;
    logic [BW-1:0]   bcdAdj;
    logic [BW+PW-1:0] convShift;

    assign startEdge = start_i & ~startPrev_q;
    assign mulBit    = |(opB_q & (WIDTH'(1) << cnt_q));
    assign partial   = mulBit ? ({{WIDTH{1'b0}}, opA_q} << cnt_q) : '0;
    assign accSum    = acc_q + partial;
    assign convShift = {bcdAdj, binSh_q} << 1;

    always_comb begin
        bcdAdj = bcd_q;
        for (int d = 0; d < BCD_DIGITS; d++) begin
            if (bcd_q[4*d +: 4] >= 4'd5) begin
                bcdAdj[4*d +: 4] = bcd_q[4*d +: 4] + 4'd3;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (startEdge && !abort_i) state_d = MULT;
            MULT: begin
                if (abort_i)                 state_d = IDLE;
                else if (cnt_q == LAST_MULT) state_d = CONV;
            end
            CONV: begin
                if (abort_i)                 state_d = IDLE;
                else if (cnt_q == LAST_CONV) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy_o      = (state_q == MULT) || (state_q == CONV);
        done_o      = (state_q == DONE);
        state_dbg_o = state_q;
    end

    // The accumulator keeps the finished product; binSh is a separate copy consumed by the shifts.
    always_comb begin
        opA_d         = opA_q;
        opB_d         = opB_q;
        acc_d         = acc_q;
        binSh_d       = binSh_q;
        bcd_d         = bcd_q;
        cnt_d         = cnt_q;
        product_d     = product_q;
        resultBcd_d   = resultBcd_q;
        resultValid_d = resultValid_q;
        case (state_q)
            IDLE: begin
                if (startEdge && !abort_i) begin
                    opA_d         = op_a_i;
                    opB_d         = op_b_i;
                    acc_d         = '0;
                    cnt_d         = '0;
                    resultValid_d = 1'b0;
                end
            end
            MULT: begin
                if (!abort_i) begin
                    acc_d = accSum;
                    if (cnt_q == LAST_MULT) begin
                        cnt_d   = '0;
                        binSh_d = accSum;
                        bcd_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            CONV: begin
                if (!abort_i) begin
                    bcd_d   = convShift[BW+PW-1:PW];
                    binSh_d = convShift[PW-1:0];
                    cnt_d   = cnt_q + 1'b1;
                    if (cnt_q == LAST_CONV) begin
                        product_d     = acc_q;
                        resultBcd_d   = convShift[BW+PW-1:PW];
                        resultValid_d = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            startPrev_q   <= 1'b0;
            opA_q         <= '0;
            opB_q         <= '0;
            acc_q         <= '0;
            binSh_q       <= '0;
            bcd_q         <= '0;
            cnt_q         <= '0;
            product_q     <= '0;
            resultBcd_q   <= '0;
            resultValid_q <= 1'b0;
        end else begin
            startPrev_q   <= start_i;
            opA_q         <= opA_d;
            opB_q         <= opB_d;
            acc_q         <= acc_d;
            binSh_q       <= binSh_d;
            bcd_q         <= bcd_d;
            cnt_q         <= cnt_d;
            product_q     <= product_d;
            resultBcd_q   <= resultBcd_d;
            resultValid_q <= resultValid_d;
        end
    end

    assign product_o      = product_q;
    assign result_bcd_o   = resultBcd_q;
    assign result_valid_o = resultValid_q;

endmodule

// File: tb/tb_module_mult_sequencer.sv
// Scoreboard bench for module_mult_sequencer: directed operations push hand-computed
// results into a queue that a done-driven monitor pops and compares.
module tb_module_mult_sequencer;

    localparam int WIDTH      = 4;
    localparam int BCD_DIGITS = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start;
    logic        abort;
    logic [3:0]  op_a;
    logic [3:0]  op_b;
    logic        busy;
    logic        done;
    logic        result_valid;
    logic [7:0]  product;
    logic [11:0] result_bcd;
    logic [1:0]  state_dbg;

    int nVectors     = 0;
    int nMiscompares = 0;

    typedef struct packed {
        logic [7:0]  prod;
        logic [11:0] bcd;
    } exp_t;

    exp_t expQ[$];

    module_mult_sequencer #(
        .WIDTH      (WIDTH),
        .BCD_DIGITS (BCD_DIGITS)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .start_i        (start),
        .abort_i        (abort),
        .op_a_i         (op_a),
        .op_b_i         (op_b),
        .busy_o         (busy),
        .done_o         (done),
        .result_valid_o (result_valid),
        .product_o      (product),
        .result_bcd_o   (result_bcd),
        .state_dbg_o    (state_dbg)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        nVectors++;
        if (actual !== expected) begin
            nMiscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    // Raises start so the next edge samples it; returns one step later (cycle 1 of the op).
    task automatic applyStimulus(input logic [3:0] a, input logic [3:0] b, input bit hold,
                                 input bit push, input logic [7:0] p, input logic [11:0] bcd);
        op_a  = a;
        op_b  = b;
        start = 1'b1;
        if (push) expQ.push_back({p, bcd});
        stepCycle();
        if (!hold) start = 1'b0;
    endtask

    task automatic waitDone(input string name, input int limit);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < limit && !seen; i++) begin
            if (done === 1'b1) seen = 1'b1;
            else stepCycle();
        end
        if (!seen) begin
            nVectors++;
            nMiscompares++;
            $display("[TB] FAIL %s: got no done within %0d cycles, expected done", name, limit);
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst === 1'b0 && done === 1'b1) begin
                if (expQ.size() == 0) begin
                    nVectors++;
                    nMiscompares++;
                    $display("[TB] FAIL unexpectedDone: got done=1, expected no pending result");
                end else begin
                    e = expQ.pop_front();
                    checkOutput("product", 32'(product), 32'(e.prod));
                    checkOutput("resultBcd", 32'(result_bcd), 32'(e.bcd));
                    checkOutput("validAtDone", 32'(result_valid), 32'd1);
                end
            end
        end
    end

    initial begin
        int errs;
        int cnt;
        start = 1'b0;
        abort = 1'b0;
        op_a  = '0;
        op_b  = '0;

        repeat (2) @(posedge clk);
        #1;
        checkOutput("rstBusy", 32'(busy), 32'd0);
        checkOutput("rstDone", 32'(done), 32'd0);
        checkOutput("rstValid", 32'(result_valid), 32'd0);
        checkOutput("rstProduct", 32'(product), 32'd0);
        checkOutput("rstBcd", 32'(result_bcd), 32'd0);
        checkOutput("rstState", 32'(state_dbg), 32'd0);
        rst = 1'b0;
        stepCycle();
        checkOutput("idleAfterRst", 32'(busy), 32'd0);

        // 7*9 with the full latency profile
        applyStimulus(4'd7, 4'd9, 1'b0, 1'b1, 8'h3F, 12'h063);
        errs = 0;
        for (int c = 1; c <= 12; c++) begin
            if (c == 1) checkOutput("stateMult", 32'(state_dbg), 32'd1);
            if (c == 5) checkOutput("stateConv", 32'(state_dbg), 32'd2);
            if (busy !== 1'b1 || done !== 1'b0) errs++;
            stepCycle();
        end
        checkOutput("busyWindow", 32'(errs), 32'd0);
        checkOutput("doneCycle13", 32'(done), 32'd1);
        checkOutput("busyCycle13", 32'(busy), 32'd0);
        checkOutput("stateDone", 32'(state_dbg), 32'd3);
        stepCycle();
        checkOutput("donePulseEnds", 32'(done), 32'd0);
        checkOutput("stateBackIdle", 32'(state_dbg), 32'd0);
        repeat (3) stepCycle();
        checkOutput("validHold", 32'(result_valid), 32'd1);
        checkOutput("productHold", 32'(product), 32'h3F);

        // Largest operands, then a zero operand
        applyStimulus(4'd15, 4'd15, 1'b0, 1'b1, 8'hE1, 12'h225);
        checkOutput("validDrop", 32'(result_valid), 32'd0);
        checkOutput("productKeptBusy", 32'(product), 32'h3F);
        waitDone("op15x15", 20);
        stepCycle();
        applyStimulus(4'd0, 4'd13, 1'b0, 1'b1, 8'h00, 12'h000);
        waitDone("op0x13", 20);
        stepCycle();

        // start held high: one operation only
        applyStimulus(4'd3, 4'd4, 1'b1, 1'b1, 8'h0C, 12'h012);
        cnt = 0;
        repeat (40) begin
            if (done === 1'b1) cnt++;
            stepCycle();
        end
        start = 1'b0;
        checkOutput("heldStartDones", 32'(cnt), 32'd1);
        checkOutput("heldStartIdle", 32'(busy), 32'd0);
        stepCycle();

        // Operand change plus a second start edge while busy
        applyStimulus(4'd6, 4'd5, 1'b0, 1'b1, 8'h1E, 12'h030);
        repeat (3) stepCycle();
        op_a  = 4'd9;
        op_b  = 4'd9;
        start = 1'b1;
        stepCycle();
        start = 1'b0;
        waitDone("op6x5", 15);
        stepCycle();
        cnt = 0;
        repeat (20) begin
            if (done === 1'b1) cnt++;
            stepCycle();
        end
        checkOutput("noExtraDone", 32'(cnt), 32'd0);

        // Abort during CONV keeps the previous result
        applyStimulus(4'd8, 4'd8, 1'b0, 1'b1, 8'h40, 12'h064);
        waitDone("op8x8", 20);
        stepCycle();
        applyStimulus(4'd5, 4'd5, 1'b0, 1'b0, 8'h00, 12'h000);
        repeat (5) stepCycle();
        abort = 1'b1;
        stepCycle();
        abort = 1'b0;
        checkOutput("abortBusy", 32'(busy), 32'd0);
        checkOutput("abortState", 32'(state_dbg), 32'd0);
        checkOutput("abortValid", 32'(result_valid), 32'd0);
        checkOutput("abortBcdKept", 32'(result_bcd), 32'h064);
        checkOutput("abortProductKept", 32'(product), 32'h40);
        cnt = 0;
        repeat (20) begin
            if (done === 1'b1) cnt++;
            stepCycle();
        end
        checkOutput("abortNoDone", 32'(cnt), 32'd0);

        op_a  = 4'd1;
        op_b  = 4'd1;
        start = 1'b1;
        abort = 1'b1;
        stepCycle();
        abort = 1'b0;
        start = 1'b0;
        checkOutput("abortWinsIdle", 32'(busy), 32'd0);
        stepCycle();
        checkOutput("abortDroppedStart", 32'(busy), 32'd0);

        // Reset during CONV with start held through release
        applyStimulus(4'd2, 4'd3, 1'b1, 1'b0, 8'h00, 12'h000);
        repeat (6) stepCycle();
        rst = 1'b1;
        #1;
        checkOutput("midRstBusy", 32'(busy), 32'd0);
        checkOutput("midRstDone", 32'(done), 32'd0);
        checkOutput("midRstValid", 32'(result_valid), 32'd0);
        checkOutput("midRstProduct", 32'(product), 32'd0);
        checkOutput("midRstBcd", 32'(result_bcd), 32'd0);
        checkOutput("midRstState", 32'(state_dbg), 32'd0);
        expQ.push_back({8'h06, 12'h006});
        @(posedge clk);
        #1;
        rst = 1'b0;
        stepCycle();
        checkOutput("restartBusy", 32'(busy), 32'd1);
        waitDone("op2x3", 20);
        start = 1'b0;
        repeat (3) stepCycle();
        checkOutput("pendingQueue", 32'(expQ.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
        $finish;
    end

endmodule

// File: doc/module_mult_sequencer.md
Name: module_mult_sequencer

Overview:
Multi-cycle controller that takes the operand pair captured by the keypad input stage and sequences a shared shift-add multiplier, then a double-dabble binary-to-BCD converter. It delivers a registered binary product and a BCD result to the 7-segment display driver. It sits between the keypad input controller (its calculate enable drives start) and the display multiplexer.

Parameters:
WIDTH, 4, operand width in bits; the product is 2*WIDTH bits.
BCD_DIGITS, 3, number of BCD output digits; must satisfy 10^BCD_DIGITS > (2^WIDTH-1)^2.

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
start  in  1  level request; a rising edge (high now, low on previous cycle) launches an operation
abort  in  1  synchronous cancel; returns the block to IDLE
op_a  in  WIDTH  multiplicand
op_b  in  WIDTH  multiplier
busy  out  1  high while in MULT or CONV
done  out  1  single-cycle completion pulse
result_valid  out  1  product/result_bcd hold a completed result
product  out  2*WIDTH  binary product
result_bcd  out  4*BCD_DIGITS  packed BCD; digit 0 in bits [3:0]
state_dbg  out  2  encoded state for debug LEDs: IDLE=0, MULT=1, CONV=2, DONE=3

Behaviour:
- Interface: one clock; reset is asynchronous and active-high.
- Reset:
  - All outputs go to 0 and the state goes to IDLE.
  - The start edge-detect register clears to 0, so a start already high when reset releases counts as a rising edge.
- IDLE:
  - On a sampled start rising edge, latch op_a and op_b, clear the accumulator, set the iteration counter to 0, clear result_valid, and go to MULT.
  - Non-edge start is ignored.
- MULT: occupies exactly WIDTH cycles.
  - Iteration i: if bit i of the latched op_b is 1, add (latched op_a << i) to the 2*WIDTH-bit accumulator. No overflow is possible.
  - After iteration WIDTH-1, go to CONV with the counter reset.
- CONV: occupies exactly 2*WIDTH cycles of double-dabble.
  - Each cycle: every BCD digit >= 5 gets +3, then the combined {bcd, bin} register shifts left by 1.
  - After the last shift, go to DONE.
- DONE: lasts one cycle.
  - done=1 and result_valid=1.
  - product and result_bcd are loaded on the edge that enters DONE.
  - Next state is IDLE.
- Latency: if the start edge is sampled at clock edge E0, busy is high for cycles 1..3*WIDTH and done is high in cycle 3*WIDTH+1. For WIDTH=4 that is cycle 13.
- Hold behaviour:
  - product and result_bcd hold their last completed values until the next DONE, across IDLE and busy periods.
  - result_valid drops when a new operation is accepted.
- start held high: produces exactly one operation. The edge detector tracks start every cycle, including while busy, so a start level that stays high after DONE does not retrigger.
- Start edge while busy or in DONE: ignored, not queued.
- Operand changes after acceptance: ignored; the latched copies are used.
- abort:
  - In MULT or CONV: go to IDLE next cycle, no done pulse. result_valid stays 0; product and result_bcd keep their previous values.
  - In IDLE or DONE: no effect.
  - Asserted together with a start edge in IDLE: abort wins and the start is dropped.
- Reset mid-operation: immediate return to IDLE with all outputs cleared; no done pulse.

Test Plan:
- op_a=7, op_b=9, start rising at E0 -> busy high cycles 1..12; done=1 only in cycle 13; product=0x3F, result_bcd=0x063, result_valid=1.
- op_a=15, op_b=15 -> product=0xE1, result_bcd=0x225; then op_a=0, op_b=13 -> product=0x00, result_bcd=0x000.
- start held high for 40 cycles with op_a=3, op_b=4 -> exactly one done pulse; result_bcd=0x012; no second operation.
- op_a=6, op_b=5 accepted; op_a/op_b change to 9/9 and start pulses again in cycle 5 -> result_bcd=0x030; no extra done.
- First op 8*8 completes (0x064); second op accepted, then abort in cycle 6 -> busy=0 in cycle 7; result_valid=0; result_bcd still 0x064; no done.
- rst pulsed during CONV -> outputs 0, state_dbg=0; with start held high through rst release, a new operation begins (edge detector cleared).
